// File: rtl/route_requester_if.sv
// Handshake bundle between an input-port requester, its flit FIFO, the switch
// controller and the crossbar. The requester side uses the master modport.
interface route_requester_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REQUEST_WIDTH = 3
) ();
  logic [DATA_WIDTH-1:0]    fifoData;
  logic                     fifoEmpty;
  logic                     fifoRdEn;
  logic                     routeReserveRequestValid;
  logic [REQUEST_WIDTH-1:0] routeReserveRequest;
  logic                     routeRelieve;
  logic                     routeReserveStatus;
  logic                     portReserved;
  logic [DATA_WIDTH-1:0]    outData;
  logic                     outValid;
  logic                     outReady;

  modport master (
    input  fifoData, fifoEmpty, routeReserveStatus, portReserved, outReady,
    output fifoRdEn, routeReserveRequestValid, routeReserveRequest, routeRelieve,
           outData, outValid
  );

  modport slave (
    output fifoData, fifoEmpty, routeReserveStatus, portReserved, outReady,
    input  fifoRdEn, routeReserveRequestValid, routeReserveRequest, routeRelieve,
           outData, outValid
  );
endinterface

// File: rtl/route_requester.sv
// Per-input requester: XY-routes each head flit, holds a reservation until
// granted, forwards the packet through the crossbar and releases the path.
module route_requester #(
  parameter int DATA_WIDTH    = 32,
  parameter int COORD_WIDTH   = 2,
  parameter int REQUEST_WIDTH = 3,
  parameter int X_ID          = 0,
  parameter int Y_ID          = 0,
  parameter int LOCAL_PORT    = 0,
  parameter int EAST_PORT     = 1,
  parameter int WEST_PORT     = 2,
  parameter int NORTH_PORT    = 3,
  parameter int SOUTH_PORT    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  route_requester_if.master   io_route,
  output logic [15:0]         o_packetCount,
  output logic                o_protocolError
);

  typedef enum logic [1:0] {IDLE, REQUEST, FORWARD, RELIEVE} state_t;

  localparam logic [COORD_WIDTH-1:0] LP_X = COORD_WIDTH'(X_ID);
  localparam logic [COORD_WIDTH-1:0] LP_Y = COORD_WIDTH'(Y_ID);

  state_t                   r_state;
  state_t                   w_nextState;
  logic [REQUEST_WIDTH-1:0] r_request;
  logic                     r_firstFlit;
  logic [15:0]              r_packetCount;
  logic                     r_protocolError;

  logic [1:0]               w_flitType;
  logic                     w_isHead;
  logic                     w_isTail;
  logic [COORD_WIDTH-1:0]   w_destX;
  logic [COORD_WIDTH-1:0]   w_destY;
  logic [REQUEST_WIDTH-1:0] w_route;
  logic                     w_outValid;
  logic                     w_pop;
  logic                     w_discard;

  assign w_flitType = io_route.fifoData[DATA_WIDTH-1:DATA_WIDTH-2];
  assign w_isHead   = w_flitType[0];
  assign w_isTail   = w_flitType[1];
  assign w_destX    = io_route.fifoData[COORD_WIDTH-1:0];
  assign w_destY    = io_route.fifoData[2*COORD_WIDTH-1:COORD_WIDTH];

  // X is resolved completely before Y, which keeps the mesh deadlock-free.
  always_comb begin
    w_route = REQUEST_WIDTH'(LOCAL_PORT);
    if (w_destX > LP_X)      w_route = REQUEST_WIDTH'(EAST_PORT);
    else if (w_destX < LP_X) w_route = REQUEST_WIDTH'(WEST_PORT);
    else if (w_destY > LP_Y) w_route = REQUEST_WIDTH'(NORTH_PORT);
    else if (w_destY < LP_Y) w_route = REQUEST_WIDTH'(SOUTH_PORT);
  end

  assign w_outValid = (r_state == FORWARD) & io_route.portReserved & ~io_route.fifoEmpty;
  assign w_pop      = w_outValid & io_route.outReady;
  // Gated by reset so a stray body flit is never popped while the router is held in reset.
  assign w_discard  = (r_state == IDLE) & i_rst_n & ~io_route.fifoEmpty & ~w_isHead;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!io_route.fifoEmpty && w_isHead) w_nextState = REQUEST;
      REQUEST: if (io_route.routeReserveStatus)     w_nextState = FORWARD;
      FORWARD: if (w_pop && w_isTail)               w_nextState = RELIEVE;
      RELIEVE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    io_route.routeReserveRequestValid = (r_state == REQUEST) || (r_state == FORWARD);
    io_route.routeReserveRequest      = r_request;
    io_route.routeRelieve             = (r_state == RELIEVE);
    io_route.outValid                 = w_outValid;
    io_route.outData                  = (r_state == FORWARD) ? io_route.fifoData : '0;
    io_route.fifoRdEn                 = w_pop | w_discard;
  end

  // The head flit itself is the first pop in FORWARD; only later heads are malformed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_request       <= '0;
      r_firstFlit     <= 1'b1;
      r_packetCount   <= '0;
      r_protocolError <= 1'b0;
    end else begin
      if (r_state == IDLE && w_nextState == REQUEST) r_request <= w_route;
      if (r_state != FORWARD) r_firstFlit <= 1'b1;
      else if (w_pop)         r_firstFlit <= 1'b0;
      if (r_state == RELIEVE) r_packetCount <= r_packetCount + 16'd1;
      if (w_discard || (w_pop && w_flitType == 2'b01 && !r_firstFlit))
        r_protocolError <= 1'b1;
    end
  end

  assign o_packetCount   = r_packetCount;
  assign o_protocolError = r_protocolError;

endmodule
